// File: rtl/spi_frame_send.sv
// SPI slave-side transmitter feeding the PS SPI0 controller inputs.
// Words enter through a valid/ready FIFO as {last, data}. The block drives
// SS, SCLK and MISO so that a frame of back-to-back words appears as one
// SS-low window with a periodic SCLK. If the FIFO runs dry mid-frame, SS stays
// low and SCLK parks at its idle level until the next word arrives.
module spi_frame_send #(
    parameter int unsigned P_WORD_WIDTH = 8,
    parameter int unsigned P_FIFO_DEPTH = 16,
    parameter int unsigned P_CLK_DIV    = 1,
    parameter bit          P_CPOL       = 1'b0,
    parameter bit          P_CPHA       = 1'b0,
    parameter bit          P_MSB_FIRST  = 1'b1,
    parameter int unsigned P_SS_GAP     = 2,
    localparam int unsigned LVL_W       = $clog2(P_FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [P_WORD_WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic                    busy,
    output logic [LVL_W-1:0]        fifo_level,
    output logic                    underrun,
    output logic                    SPI0_MISO_I,
    output logic                    SPI0_SCLK_I,
    output logic                    SPI0_SS_I
);

    localparam int unsigned PTR_W  = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * P_WORD_WIDTH);
    localparam int unsigned GAP_W  = (P_SS_GAP > 1) ? $clog2(P_SS_GAP) : 1;

    localparam logic [7:0]        DIV_MAX   = 8'(P_CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * P_WORD_WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(P_SS_GAP - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(P_FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StShift,
        StStall,
        StTail,
        StGap
    } state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [P_WORD_WIDTH:0]   mem_q [P_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ready_q;
    logic                    push, pop, fifo_empty;
    logic [P_WORD_WIDTH-1:0] head_data;
    logic                    head_last;

    // Ready reflects the level before any pop, so a full FIFO never takes a
    // word even in the cycle it pops one.
    assign push       = s_valid & ready_q;
    assign fifo_empty = (level_q == '0);
    assign {head_last, head_data} = mem_q[rd_ptr_q];
    assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);

    // Storage array, written on an accepted handshake.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_last, s_data};
        end
    end

    // Pointers, level and registered ready; depth is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ready_q <= (level_d != LVL_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [7:0]              div_q, div_d;
    logic [EDGE_W-1:0]       edge_q, edge_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [P_WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic                    last_q, last_d;
    logic                    sclk_q, sclk_d;
    logic                    ss_q, ss_d;
    logic                    miso_q, miso_d;
    logic                    underrun_q, underrun_d;
    logic                    load;

    function automatic logic first_bit(input logic [P_WORD_WIDTH-1:0] w);
        return P_MSB_FIRST ? w[P_WORD_WIDTH-1] : w[0];
    endfunction

    function automatic logic [P_WORD_WIDTH-1:0] advance(input logic [P_WORD_WIDTH-1:0] w);
        return P_MSB_FIRST ? {w[P_WORD_WIDTH-2:0], 1'b0} : {1'b0, w[P_WORD_WIDTH-1:1]};
    endfunction

    // State and output registers; everything seen by the PS is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            edge_q     <= '0;
            gap_q      <= '0;
            shreg_q    <= '0;
            last_q     <= 1'b0;
            sclk_q     <= P_CPOL;
            ss_q       <= 1'b1;
            miso_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            gap_q      <= gap_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            miso_q     <= miso_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state logic: edge k of a word is leading when k is even.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        gap_d      = gap_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        sclk_d     = sclk_q;
        ss_d       = ss_q;
        miso_d     = miso_q;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            StIdle, StStall: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    ss_d    = 1'b0;
                    div_d   = '0;
                    state_d = StLead;
                end
            end
            StLead, StShift: begin
                if (div_q == DIV_MAX) begin
                    div_d   = '0;
                    sclk_d  = ~sclk_q;
                    state_d = StShift;
                    if (edge_q == EDGE_LAST) begin
                        edge_d = '0;
                        if (last_q) begin
                            state_d = StTail;
                        end else if (!fifo_empty) begin
                            // Next word continues on the same SCLK cadence.
                            load = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = StStall;
                        end
                    end else begin
                        edge_d = edge_q + 1'b1;
                        // CPHA=0 drives on trailing edges, CPHA=1 on leading.
                        if (P_CPHA ? ~edge_q[0] : edge_q[0]) begin
                            miso_d  = first_bit(shreg_q);
                            shreg_d = advance(shreg_q);
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StTail: begin
                if (div_q == DIV_MAX) begin
                    ss_d    = 1'b1;
                    miso_d  = 1'b0;
                    div_d   = '0;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GAP_MAX) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Word load: CPHA=0 presents the first bit immediately.
        if (load) begin
            last_d = head_last;
            edge_d = '0;
            if (P_CPHA) begin
                shreg_d = head_data;
            end else begin
                miso_d  = first_bit(head_data);
                shreg_d = advance(head_data);
            end
        end
    end

    assign pop         = load;
    assign s_ready     = ready_q;
    assign fifo_level  = level_q;
    assign underrun    = underrun_q;
    assign busy        = ~ss_q | ~fifo_empty | (state_q == StGap);
    assign SPI0_MISO_I = miso_q;
    assign SPI0_SCLK_I = sclk_q;
    assign SPI0_SS_I   = ss_q;

endmodule
